// File: rtl/store_buffer.sv
// Posted-store FIFO between the CPU data port and a handshaked memory.
// Optional load forwarding from the buffer when STB_FWD_EN is defined.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic          cpu_memw_i,
  input  logic          cpu_memr_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE, LREQ, LWAIT, LDONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [AW-3:0] addr_q [DEPTH];
  logic [AW-3:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [DW-1:0] ld_q, ld_d;

  logic          full, empty;
  logic          enq, pop;
  logic          hit;
  logic [DW-1:0] fwd_data;
  logic [AW-3:0] cpu_word;
  logic          unused_addr_lsb;

  assign cpu_word        = cpu_addr_i[AW-1:2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];
  assign full            = (cnt_q == (PW+1)'(DEPTH));
  assign empty           = (cnt_q == '0);

`ifdef STB_FWD_EN
  // Youngest valid entry with a matching word address wins
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < cnt_q) &&
          (addr_q[head_q + PW'(k)] == cpu_word)) begin
        hit      = 1'b1;
        fwd_data = data_q[head_q + PW'(k)];
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign fwd_data = '0;
`endif

  // Next-state, FIFO update and memory/CPU outputs
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ld_d        = ld_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    pop         = 1'b0;
    enq         = cpu_memw_i & ~full;

    if (cpu_memw_i && full) cpu_stall_o = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {addr_q[head_q], 2'b00};
          mem_wdata_o = data_q[head_q];
          pop         = mem_gnt_i;
        end
        if (cpu_memr_i) begin
          if (hit) begin
            cpu_rdata_o = fwd_data;
          end else begin
            cpu_stall_o = 1'b1;
            if (empty) state_d = LREQ;
          end
        end
      end
      LREQ: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_word, 2'b00};
        cpu_stall_o = 1'b1;
        if (mem_gnt_i) state_d = LWAIT;
      end
      LWAIT: begin
        cpu_stall_o = 1'b1;
        if (mem_rvalid_i) begin
          ld_d    = mem_rdata_i;
          state_d = LDONE;
        end
      end
      LDONE: begin
        cpu_rdata_o = ld_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enq) begin
      addr_d[tail_q] = cpu_word;
      data_d[tail_q] = cpu_wdata_i;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);

    unique case (1'b1)
      enq && !pop: cnt_d = cnt_q + (PW+1)'(1);
      pop && !enq: cnt_d = cnt_q - (PW+1)'(1);
      default:     cnt_d = cnt_q;
    endcase
  end

  // State, pointer and storage registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: memory writes are
// predicted at store acceptance, load data from a shadow map.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_wdata_i = '0;
  logic          cpu_memw_i = 1'b0;
  logic          cpu_memr_i = 1'b0;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_memw_i   (cpu_memw_i),
    .cpu_memr_i   (cpu_memr_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] shadow    [logic [31:0]];
  logic [31:0] exp_rd_addr = '0;
  logic [31:0] rd_addr = '0;
  bit          rd_pend = 1'b0;
  bit          gnt_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  function automatic logic [31:0] sread(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  // Memory model: grants mid-cycle, returns read data one cycle later
  always @(negedge clk_i) begin
    wr_t e;
    #2;
    if (!rst_n) begin
      rd_pend      = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
    end else begin
      mem_rvalid_i = rd_pend;
      mem_rdata_i  = rd_pend ? mread(rd_addr) : 32'h0;
      rd_pend      = 1'b0;
      mem_gnt_i    = gnt_en && mem_req_o;
      if (mem_gnt_i) begin
        if (mem_we_o) begin
          check("wr_expected", 64'(wq.size() != 0), 64'd1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            check("wr_addr", 64'(mem_addr_o), 64'(e.a));
            check("wr_data", 64'(mem_wdata_o), 64'(e.d));
            mem_model[mem_addr_o] = mem_wdata_o;
          end
        end else begin
          check("rd_order", 64'(wq.size()), 64'd0);
          check("rd_addr", 64'(mem_addr_o), 64'(exp_rd_addr));
          rd_pend = 1'b1;
          rd_addr = mem_addr_o;
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a,
                          input logic [31:0] d,
                          output bit st1);
    bit ok;
    @(negedge clk_i);
    cpu_addr_i  = a;
    cpu_wdata_i = d;
    cpu_memw_i  = 1'b1;
    st1 = 1'b0;
    ok  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #3;
      if (!cpu_stall_o) begin
        ok = 1'b1;
        break;
      end
      if (n == 0) st1 = 1'b1;
      @(negedge clk_i);
    end
    check("st_accept", 64'(ok), 64'd1);
    if (ok) begin
      wq.push_back('{a: a & ~32'h3, d: d});
      shadow[a & ~32'h3] = d;
    end
    @(posedge clk_i);
    #1 cpu_memw_i = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls);
    bit ok;
    @(negedge clk_i);
    cpu_addr_i  = a;
    cpu_memr_i  = 1'b1;
    exp_rd_addr = a & ~32'h3;
    stalls = 0;
    ok     = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #3;
      if (!cpu_stall_o) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk_i);
    end
    check("ld_done", 64'(ok), 64'd1);
    if (ok) check("ld_data", 64'(cpu_rdata_o), 64'(sread(a & ~32'h3)));
    @(posedge clk_i);
    #1 cpu_memr_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      #3;
      if (wq.size() == 0 && !mem_req_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int s;

    #12;
    check("rst_stall", 64'(cpu_stall_o), 64'd0);
    check("rst_req",   64'(mem_req_o),   64'd0);
    check("rst_we",    64'(mem_we_o),    64'd0);
    check("rst_addr",  64'(mem_addr_o),  64'd0);
    check("rst_rdata", 64'(cpu_rdata_o), 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1;

    mem_model[32'h40] = 32'h1234;
    shadow[32'h40]    = 32'h1234;
    mem_model[32'h60] = 32'hCAFE;
    shadow[32'h60]    = 32'hCAFE;

    // reset while three stores wait to drain
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'h200 + 32'(4 * i), 32'(i + 9), st);
    @(negedge clk_i);
    #3;
    check("req_pre_rst", 64'(mem_req_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req",   64'(mem_req_o),   64'd0);
    check("rst_mid_stall", 64'(cpu_stall_o), 64'd0);
    wq.delete();
    @(negedge clk_i);
    rst_n  = 1'b1;
    gnt_en = 1'b1;
    repeat (10) @(negedge clk_i);
    #3;
    check("req_post_rst", 64'(mem_req_o), 64'd0);

    // fill to DEPTH, fifth store stalls until memory grants
    gnt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'(4 * i), 32'(i + 1), st);
      check("fill_stall", 64'(st), 64'd0);
    end
    fork
      do_store(32'h10, 32'd5, st);
      begin
        repeat (4) @(negedge clk_i);
        gnt_en = 1'b1;
      end
    join
    check("full_stall", 64'(st), 64'd1);
    wait_drain();

    // two stores to one word, then a load of that word
    gnt_en = 1'b0;
    do_store(32'h20, 32'hAAAA, st);
    do_store(32'h20, 32'hBBBB, st);
    fork
      do_load(32'h22, s);
      begin
        repeat (6) @(negedge clk_i);
        gnt_en = 1'b1;
      end
    join
`ifdef STB_FWD_EN
    check("fwd_stall", 64'(s), 64'd0);
`else
    check("nofwd_stall", 64'(s > 0), 64'd1);
`endif
    wait_drain();

    // minimum miss on an empty buffer
    do_load(32'h40, s);
    check("miss_stall", 64'(s), 64'd3);
    @(negedge clk_i);
    #3;
    check("rdata_clear", 64'(cpu_rdata_o), 64'd0);

    // load miss behind a buffered store
    do_store(32'h50, 32'd7, st);
    do_load(32'h60, s);
    check("order_stall", 64'(s), 64'd4);
    wait_drain();

    // steady enqueue+pop with two entries resident, wraps pointers
    gnt_en = 1'b0;
    do_store(32'h100, 32'h100, st);
    do_store(32'h104, 32'h104, st);
    gnt_en = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      do_store(32'h108 + 32'(4 * i), 32'h500 + 32'(i), st);
      check("stream_stall", 64'(st), 64'd0);
    end
    wait_drain();
    do_load(32'h124, s);
    do_load(32'h100, s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
